// File: rtl/id_operand_unit.sv
// id_operand_unit
// Decode-stage operand block for the 16-bit pipelined processor.
//   - REG_CNT x DATA_W register file, two combinational read ports, one
//     synchronous write port (R0 hardwired to zero, no write-to-read bypass)
//   - 6-bit to DATA_W immediate extender (sign or zero)
//   - equality comparator for branch resolution
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rs1, rs2 -> bus1/bus2 combinational register reads
//   rd, reg_wr, wb_data   write-back port, written on the rising edge
//   imm_in, ext_op        immediate and extension mode -> imm_out
//   cmp_a, cmp_b,         comparator operands; comp_src=1 compares cmp_a
//   comp_src -> comp_res    against zero instead of cmp_b
module id_operand_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_CNT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(REG_CNT)-1:0] rs1,
    input  logic [$clog2(REG_CNT)-1:0] rs2,
    input  logic [$clog2(REG_CNT)-1:0] rd,
    input  logic                       reg_wr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic [DATA_W-1:0]          bus1,
    output logic [DATA_W-1:0]          bus2,
    input  logic [5:0]                 imm_in,
    input  logic                       ext_op,
    output logic [DATA_W-1:0]          imm_out,
    input  logic [DATA_W-1:0]          cmp_a,
    input  logic [DATA_W-1:0]          cmp_b,
    input  logic                       comp_src,
    output logic                       comp_res
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];
    logic [DATA_W-1:0] cmp_b_sel;

    // Next-state of the register file; R0 is forced back to zero so it
    // stays constant regardless of rd.
    always_comb begin
        regs_d = regs_q;
        if (reg_wr && (rd != '0)) begin
            regs_d[rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come straight from the flops: a same-cycle write is only seen
    // after the edge; hazards are handled by the external forwarding mux.
    always_comb begin
        bus1 = (rs1 == '0) ? '0 : regs_q[rs1];
        bus2 = (rs2 == '0) ? '0 : regs_q[rs2];
    end

    always_comb begin
        if (ext_op) begin
            imm_out = {{(DATA_W-6){imm_in[5]}}, imm_in};
        end else begin
            imm_out = {{(DATA_W-6){1'b0}}, imm_in};
        end
    end

    always_comb begin
        cmp_b_sel = comp_src ? '0 : cmp_b;
        comp_res  = (cmp_a == cmp_b_sel);
    end

endmodule

// File: tb/tb_id_operand_unit.sv
`timescale 1ns/1ps
module tb_id_operand_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rs1, rs2, rd;
    logic        reg_wr;
    logic [15:0] wb_data;
    logic [15:0] bus1, bus2;
    logic [5:0]  imm_in;
    logic        ext_op;
    logic [15:0] imm_out;
    logic [15:0] cmp_a, cmp_b;
    logic        comp_src;
    logic        comp_res;

    id_operand_unit #(
        .DATA_W  (16),
        .REG_CNT (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .reg_wr   (reg_wr),
        .wb_data  (wb_data),
        .bus1     (bus1),
        .bus2     (bus2),
        .imm_in   (imm_in),
        .ext_op   (ext_op),
        .imm_out  (imm_out),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .comp_src (comp_src),
        .comp_res (comp_res)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] model_regs [8];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", obs, ~obs);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        return (a == 3'd0) ? 16'h0000 : model_regs[a];
    endfunction

    function automatic logic [15:0] model_ext(input logic [5:0] v, input logic s);
        return (s && v[5]) ? {10'h3FF, v} : {10'h000, v};
    endfunction

    function automatic logic model_cmp(input logic [15:0] a, input logic [15:0] b, input logic src);
        return src ? (a == 16'h0000) : (a == b);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    endtask

    // Push expected read values for the current addresses, settle, compare.
    task automatic check_reads(input string t1, input string t2);
        push_exp(t1, model_read(rs1));
        push_exp(t2, model_read(rs2));
        #1;
        pop_check(bus1);
        pop_check(bus2);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        rd      = a;
        wb_data = d;
        reg_wr  = 1'b1;
        @(posedge clk);
        #1;
        if (a != 3'd0) model_regs[a] = d;
        reg_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        rd       = '0;
        reg_wr   = 1'b0;
        wb_data  = '0;
        imm_in   = '0;
        ext_op   = 1'b0;
        cmp_a    = '0;
        cmp_b    = '0;
        comp_src = 1'b0;
        clear_model();

        #25;
        rst_n = 1'b1;

        // Populate some registers so the reset test has something to clear.
        do_write(3'd3, 16'h5555);
        do_write(3'd6, 16'h7777);
        rs1 = 3'd3; rs2 = 3'd6;
        check_reads("pre_rst_bus1", "pre_rst_bus2");

        // Mid-cycle asynchronous reset with a pending write.
        @(posedge clk);
        #2;
        reg_wr  = 1'b1;
        rd      = 3'd3;
        wb_data = 16'hBEEF;
        rst_n   = 1'b0;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i);
            rs2 = 3'(7 - i);
            check_reads("rst_bus1", "rst_bus2");
        end
        reg_wr = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i);
            rs2 = 3'(i);
            check_reads("post_rst_bus1", "post_rst_bus2");
        end

        // Basic write/read and R0 write suppression.
        do_write(3'd5, 16'h1234);
        do_write(3'd2, 16'hFFFF);
        rs1 = 3'd5; rs2 = 3'd2;
        check_reads("wr_bus1", "wr_bus2");
        do_write(3'd0, 16'hAAAA);
        rs1 = 3'd0; rs2 = 3'd0;
        push_exp("r0_bus1", 16'h0000);
        push_exp("r0_bus2", 16'h0000);
        #1;
        pop_check(bus1);
        pop_check(bus2);

        // No bypass: old value before the edge, new value after it.
        do_write(3'd4, 16'h0011);
        @(negedge clk);
        reg_wr = 1'b1; rd = 3'd4; wb_data = 16'h0022;
        rs1 = 3'd4; rs2 = 3'd4;
        push_exp("nobyp_pre", 16'h0011);
        #1;
        pop_check(bus1);
        @(posedge clk);
        #1;
        model_regs[4] = 16'h0022;
        push_exp("nobyp_post", 16'h0022);
        pop_check(bus1);
        @(negedge clk);
        reg_wr = 1'b0; wb_data = 16'h0099;
        @(posedge clk);
        #1;
        push_exp("wr_gated", 16'h0022);
        pop_check(bus1);

        // Extender corners.
        imm_in = 6'b100000; ext_op = 1'b1;
        push_exp("ext_sign_neg", 16'hFFE0);
        #1; pop_check(imm_out);
        ext_op = 1'b0;
        push_exp("ext_zero", 16'h0020);
        #1; pop_check(imm_out);
        imm_in = 6'b011111; ext_op = 1'b1;
        push_exp("ext_sign_pos", 16'h001F);
        #1; pop_check(imm_out);

        // Comparator corners.
        cmp_a = 16'h00AB; cmp_b = 16'h00AB; comp_src = 1'b0;
        push_exp("cmp_eq", 16'h0001);
        #1; pop_check({15'h0, comp_res});
        cmp_b = 16'h00AC;
        push_exp("cmp_ne", 16'h0000);
        #1; pop_check({15'h0, comp_res});
        comp_src = 1'b1; cmp_a = 16'h0000;
        push_exp("cmp_zero_t", 16'h0001);
        #1; pop_check({15'h0, comp_res});
        cmp_a = 16'h8000;
        push_exp("cmp_zero_f", 16'h0000);
        #1; pop_check({15'h0, comp_res});

        // Random traffic against the register model.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            rs1     = 3'($urandom_range(7));
            rs2     = ($urandom_range(3) == 0) ? rs1 : 3'($urandom_range(7));
            rd      = 3'($urandom_range(7));
            reg_wr  = 1'($urandom_range(1));
            wb_data = 16'($urandom);
            imm_in  = 6'($urandom_range(63));
            ext_op  = 1'($urandom_range(1));
            cmp_a   = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
            cmp_b   = ($urandom_range(1) == 0) ? cmp_a : 16'($urandom);
            comp_src = 1'($urandom_range(1));
            push_exp("rnd_bus1", model_read(rs1));
            push_exp("rnd_bus2", model_read(rs2));
            push_exp("rnd_imm", model_ext(imm_in, ext_op));
            push_exp("rnd_cmp", {15'h0, model_cmp(cmp_a, cmp_b, comp_src)});
            #1;
            pop_check(bus1);
            pop_check(bus2);
            pop_check(imm_out);
            pop_check({15'h0, comp_res});
            @(posedge clk);
            #1;
            if (reg_wr && rd != 3'd0) model_regs[rd] = wb_data;
        end

        // Final sweep of the whole file after random traffic.
        reg_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i);
            rs2 = 3'(7 - i);
            check_reads("final_bus1", "final_bus2");
        end

        check_eq("sb_leftover", 16'(sb_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_operand_unit.md
# id_operand_unit

Decode-stage operand block for the 16-bit pipelined processor. It combines three functions:
- an 8 x 16-bit register file with two combinational read ports and one synchronous write port;
- a 6-bit to 16-bit immediate extender;
- an equality comparator for branch resolution.

It sits in the ID stage between the instruction register and the forwarding muxes. Write-back from the WB stage drives its write port.

## Interface
Parameters:
- `DATA_W`, 16, register and bus width.
- `REG_CNT`, 8, number of registers; addressed by 3 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rs1`  in  3  read address, port 1.
- `rs2`  in  3  read address, port 2.
- `rd`  in  3  write address (WB-stage destination).
- `reg_wr`  in  1  write enable (WB-stage RegWr).
- `wb_data`  in  16  write data.
- `bus1`  out  16  data at `rs1`.
- `bus2`  out  16  data at `rs2`.
- `imm_in`  in  6  instruction[5:0].
- `ext_op`  in  1  1 = sign-extend, 0 = zero-extend.
- `imm_out`  out  16  extended immediate.
- `cmp_a`  in  16  comparator operand A (forwarded Bus2).
- `cmp_b`  in  16  comparator operand B (forwarded Bus1).
- `comp_src`  in  1  1 = compare `cmp_a` against 0, 0 = compare against `cmp_b`.
- `comp_res`  out  1  equality result.

## Operation
Register file:
- R0 is hardwired to 0x0000. Reads of R0 return 0. Writes to R0 are ignored.
- R1..R7 are writable.
- `bus1` = R[`rs1`] and `bus2` = R[`rs2`], purely combinational.
- Write: on the rising `clk` edge with `reg_wr`=1 and `rd`≠0, R[`rd`] <= `wb_data`.
- `reg_wr`=0: no register changes.
- No internal write-to-read bypass. Same-cycle WB→ID hazards are resolved by the external forwarding mux, whose select 3 chooses WBData.

Extender:
- `ext_op`=1: `imm_out` = {{10{imm_in[5]}}, imm_in}.
- `ext_op`=0: `imm_out` = {10'b0, imm_in}.
- Combinational. No arithmetic is performed here.

Comparator:
- Operand B is `cmp_b` when `comp_src`=0, and 16'h0000 when `comp_src`=1.
- `comp_res` = 1 when `cmp_a` == B on all 16 bits, else 0.
- Combinational. Signed and unsigned views are identical.

Reset:
- `rst_n`=0 asynchronously clears R1..R7 to 0x0000, independent of `clk`.
- Writes are blocked while `rst_n`=0.
- If reset asserts mid-cycle while `reg_wr`=1, reset wins. At the next edge after deassertion, the write occurs only if `reg_wr` is still 1.

## Timing
- Read ports, extender and comparator are zero-latency combinational paths. No registered outputs.
- A write at edge N is visible on `bus1`/`bus2` immediately after edge N (delta delay). Before edge N, the reads return the old value.
- Simultaneous read and write of the same register in one cycle: the read returns the pre-edge value until the edge.
- Two read ports addressing the same register both return the same value.
- Output values during reset:
  - `bus1`/`bus2` = 0x0000 for every address.
  - `imm_out` and `comp_res` follow their inputs.
- No handshake, no stall input. The enclosing stage gates `reg_wr`.

## Test plan
- **Reset:** drive `rst_n`=0 mid-cycle with `reg_wr`=1, `rd`=3, `wb_data`=0xBEEF. Sweep `rs1`/`rs2` over 0..7 → all reads 0x0000 immediately, without a clock edge. After release with `reg_wr`=0, reads stay 0x0000.
- **Write/read:** write 0x1234 to R5 and 0xFFFF to R2. Set `rs1`=5, `rs2`=2 → `bus1`=0x1234, `bus2`=0xFFFF. Then write 0xAAAA to R0 → `rs1`=0 reads 0x0000.
- **No-bypass and enable gating:**
  - R4 holds 0x0011. Set `reg_wr`=1, `rd`=4, `wb_data`=0x0022, `rs1`=4 → `bus1`=0x0011 before the edge, 0x0022 after it.
  - Set `reg_wr`=0 with new data → R4 unchanged.
- **Extender:**
  - `imm_in`=6'b100000, `ext_op`=1 → 0xFFE0; `ext_op`=0 → 0x0020.
  - `imm_in`=6'b011111, `ext_op`=1 → 0x001F.
- **Comparator:**
  - `cmp_a`=0x00AB, `cmp_b`=0x00AB, `comp_src`=0 → 1.
  - `cmp_b`=0x00AC → 0.
  - `comp_src`=1 with `cmp_a`=0x0000 → 1; with `cmp_a`=0x8000 → 0.
- **Random:** 1000 random cycles of writes and reads checked against a scoreboard model of R0..R7, including `rd`=0 writes and same-register reads on both ports.
